memory_stage: RTL and testbench

Memory-access stage of the pipelined RISC-V core, sitting directly downstream of the execute/memory pipeline register. It consumes the registered ALU result, store data and memory-stage control signals. It performs byte/half/word loads and stores against an internal word-organised data RAM and registers everything into the memory/writeback boundary. It also handles pipeline stall and flush for that boundary, and flags misaligned or unsupported accesses.

---
 rtl/memory_stage_if.sv | 35 +++
 rtl/memory_stage.sv | 131 +++++++++++++
 tb/tb_memory_stage.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/memory_stage_if.sv
// Bundle of the memory-stage (M) inputs and the memory/writeback (W) register outputs.
interface memory_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  StallM;
  logic                  FlushM;
  logic                  RegWriteM;
  logic                  MemWriteM;
  logic [1:0]            ResultSrcM;
  logic [2:0]            funct3M;
  logic [4:0]            RdM;
  logic [DATA_WIDTH-1:0] ALUResultM;
  logic [DATA_WIDTH-1:0] WriteDataM;
  logic [DATA_WIDTH-1:0] PCPlus4M;

  logic                  RegWriteW;
  logic [1:0]            ResultSrcW;
  logic [4:0]            RdW;
  logic [DATA_WIDTH-1:0] ALUResultW;
  logic [DATA_WIDTH-1:0] ReadDataW;
  logic [DATA_WIDTH-1:0] PCPlus4W;
  logic                  MemFaultW;

  modport master (
    output StallM, FlushM, RegWriteM, MemWriteM, ResultSrcM, funct3M, RdM,
           ALUResultM, WriteDataM, PCPlus4M,
    input  RegWriteW, ResultSrcW, RdW, ALUResultW, ReadDataW, PCPlus4W, MemFaultW
  );

  modport slave (
    input  StallM, FlushM, RegWriteM, MemWriteM, ResultSrcM, funct3M, RdM,
           ALUResultM, WriteDataM, PCPlus4M,
    output RegWriteW, ResultSrcW, RdW, ALUResultW, ReadDataW, PCPlus4W, MemFaultW
  );
endinterface

// File: rtl/memory_stage.sv
// RV32 memory-access stage: byte/half/word loads and stores on a word-organised RAM,
// fault detection, and the stall/flush-controlled memory/writeback register.
module memory_stage #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input logic           clk,
  input logic           rst_n,
  memory_stage_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  logic [AW-1:0]         idx;
  logic [1:0]            off;
  logic                  is_load;
  logic                  access;
  logic                  bad_f3;
  logic                  misalign;
  logic                  fault;
  logic                  st_en;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wr_lanes;
  logic                  unused_addr_bits;

  assign idx              = bus.ALUResultM[AW+1:2];
  assign off              = bus.ALUResultM[1:0];
  assign unused_addr_bits = ^bus.ALUResultM[DATA_WIDTH-1:AW+2];
  assign is_load          = (bus.ResultSrcM == 2'b01);
  assign access           = is_load | bus.MemWriteM;

  always_comb begin
    bad_f3 = 1'b0;
    if (is_load) begin
      case (bus.funct3M)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: bad_f3 = 1'b0;
        default:                                bad_f3 = 1'b1;
      endcase
    end
    if (bus.MemWriteM && (bus.funct3M > 3'b010)) bad_f3 = 1'b1;
  end

  // funct3[1:0] encodes size for both loads and stores (01 half, 10 word)
  assign misalign = ((bus.funct3M[1:0] == 2'b01) && off[0]) ||
                    ((bus.funct3M[1:0] == 2'b10) && (off != 2'b00));
  assign fault    = access & (bad_f3 | misalign);
  assign st_en    = bus.MemWriteM & ~fault & ~bus.StallM & ~bus.FlushM & rst_n;

  assign rd_word = mem_q[idx];
  assign rd_byte = rd_word[8*off +: 8];
  assign rd_half = off[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    case (bus.funct3M)
      3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_ext = {24'b0, rd_byte};
      3'b101:  load_ext = {16'b0, rd_half};
      default: load_ext = rd_word;
    endcase
  end

  always_comb begin
    case (bus.funct3M[1:0])
      2'b00: begin
        be       = 4'b0001 << off;
        wr_lanes = {4{bus.WriteDataM[7:0]}};
      end
      2'b01: begin
        be       = off[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{bus.WriteDataM[15:0]}};
      end
      default: begin
        be       = 4'b1111;
        wr_lanes = bus.WriteDataM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (st_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

  logic                  reg_write_q, reg_write_d;
  logic [1:0]            result_src_q;
  logic [4:0]            rd_q;
  logic [DATA_WIDTH-1:0] alu_result_q;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic [DATA_WIDTH-1:0] pc_plus4_q;
  logic                  mem_fault_q;

  assign reg_write_d = bus.RegWriteM & ~(fault & is_load);
  assign read_data_d = fault ? '0 : load_ext;

  always_ff @(posedge clk) begin
    if (!rst_n || bus.FlushM) begin
      reg_write_q  <= 1'b0;
      result_src_q <= 2'b00;
      rd_q         <= 5'd0;
      alu_result_q <= '0;
      read_data_q  <= '0;
      pc_plus4_q   <= '0;
      mem_fault_q  <= 1'b0;
    end else if (!bus.StallM) begin
      reg_write_q  <= reg_write_d;
      result_src_q <= bus.ResultSrcM;
      rd_q         <= bus.RdM;
      alu_result_q <= bus.ALUResultM;
      read_data_q  <= read_data_d;
      pc_plus4_q   <= bus.PCPlus4M;
      mem_fault_q  <= fault;
    end
  end

  assign bus.RegWriteW  = reg_write_q;
  assign bus.ResultSrcW = result_src_q;
  assign bus.RdW        = rd_q;
  assign bus.ALUResultW = alu_result_q;
  assign bus.ReadDataW  = read_data_q;
  assign bus.PCPlus4W   = pc_plus4_q;
  assign bus.MemFaultW  = mem_fault_q;
endmodule

// File: tb/tb_memory_stage.sv
// Vector/scoreboard bench for memory_stage: loads, stores, faults, stall/flush, wrap-around.
module tb_memory_stage;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  memory_stage_if #(.DATA_WIDTH(32)) bus ();
  memory_stage #(.DATA_WIDTH(32), .DEPTH_WORDS(1024)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        rst, st, fl, rw, mw;
    logic [1:0]  rs;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] alu, wd, pc;
    logic        e_rw;
    logic [1:0]  e_rs;
    logic [4:0]  e_rd;
    logic [31:0] e_alu, e_data, e_pc;
    logic        e_flt;
    logic        chk;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  int   step_no = 0;
  vec_t exp_q[$];
  vec_t last;
  vec_t tbl[$];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", nm, step_no, act, exp);
    end
  endtask

  function automatic vec_t base();
    vec_t v;
    v = '{default: '0};
    v.rst  = 1'b1;
    v.pc   = 32'h100;
    v.e_pc = 32'h100;
    return v;
  endfunction

  function automatic vec_t LD(input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] d, input logic flt);
    vec_t v = base();
    v.rw = 1'b1; v.rs = 2'b01; v.f3 = f3; v.rd = 5'd7; v.alu = a;
    v.e_rw = ~flt; v.e_rs = 2'b01; v.e_rd = 5'd7; v.e_alu = a;
    v.e_data = flt ? 32'h0 : d; v.e_flt = flt; v.chk = 1'b1;
    return v;
  endfunction

  function automatic vec_t ST(input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] d, input logic flt);
    vec_t v = base();
    v.mw = 1'b1; v.f3 = f3; v.alu = a; v.wd = d;
    v.e_alu = a; v.e_flt = flt;
    return v;
  endfunction

  function automatic vec_t PASS();
    vec_t v = base();
    v.rw = 1'b1; v.rs = 2'b10; v.rd = 5'd5; v.alu = 32'h55; v.pc = 32'h104;
    v.e_rw = 1'b1; v.e_rs = 2'b10; v.e_rd = 5'd5; v.e_alu = 32'h55; v.e_pc = 32'h104;
    return v;
  endfunction

  function automatic vec_t BUB(input vec_t vi);
    vec_t v = vi;
    v.e_rw = 1'b0; v.e_rs = 2'b00; v.e_rd = 5'd0; v.e_alu = 32'h0;
    v.e_data = 32'h0; v.e_pc = 32'h0; v.e_flt = 1'b0; v.chk = 1'b1;
    return v;
  endfunction

  function automatic vec_t STALLED(input vec_t vi, input vec_t prev);
    vec_t v = vi;
    v.st = 1'b1;
    v.e_rw = prev.e_rw; v.e_rs = prev.e_rs; v.e_rd = prev.e_rd; v.e_alu = prev.e_alu;
    v.e_data = prev.e_data; v.e_pc = prev.e_pc; v.e_flt = prev.e_flt; v.chk = prev.chk;
    return v;
  endfunction

  task automatic step(input vec_t v);
    vec_t e;
    rst_n          = v.rst;
    bus.StallM     = v.st;
    bus.FlushM     = v.fl;
    bus.RegWriteM  = v.rw;
    bus.MemWriteM  = v.mw;
    bus.ResultSrcM = v.rs;
    bus.funct3M    = v.f3;
    bus.RdM        = v.rd;
    bus.ALUResultM = v.alu;
    bus.WriteDataM = v.wd;
    bus.PCPlus4M   = v.pc;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    step_no++;
    e = exp_q.pop_front();
    cmp("RegWriteW",  {31'b0, bus.RegWriteW}, {31'b0, e.e_rw});
    cmp("ResultSrcW", {30'b0, bus.ResultSrcW}, {30'b0, e.e_rs});
    cmp("RdW",        {27'b0, bus.RdW}, {27'b0, e.e_rd});
    cmp("ALUResultW", bus.ALUResultW, e.e_alu);
    cmp("PCPlus4W",   bus.PCPlus4W, e.e_pc);
    cmp("MemFaultW",  {31'b0, bus.MemFaultW}, {31'b0, e.e_flt});
    if (e.chk) cmp("ReadDataW", bus.ReadDataW, e.e_data);
    last = e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog step=%0d got=timeout want=finish", step_no);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    vec_t pre;

    for (int i = 0; i < 2; i++) begin
      v = base();
      v.rst = 1'b0; v.st = 1'($urandom); v.fl = 1'($urandom);
      v.rw = 1'($urandom); v.mw = 1'($urandom); v.rs = 2'($urandom);
      v.f3 = 3'($urandom); v.rd = 5'($urandom); v.alu = $urandom;
      v.wd = $urandom; v.pc = $urandom;
      step(BUB(v));
    end

    tbl.push_back(ST(3'b010, 32'h10,   32'hDEADBEEF, 1'b0));
    tbl.push_back(LD(3'b010, 32'h10,   32'hDEADBEEF, 1'b0));
    tbl.push_back(ST(3'b000, 32'h12,   32'hFFFFFF5A, 1'b0));
    tbl.push_back(LD(3'b010, 32'h10,   32'hDE5ABEEF, 1'b0));
    tbl.push_back(LD(3'b000, 32'h13,   32'hFFFFFFDE, 1'b0));
    tbl.push_back(LD(3'b100, 32'h13,   32'h000000DE, 1'b0));
    tbl.push_back(LD(3'b001, 32'h12,   32'hFFFFDE5A, 1'b0));
    tbl.push_back(LD(3'b101, 32'h10,   32'h0000BEEF, 1'b0));
    tbl.push_back(LD(3'b010, 32'h11,   32'h0,        1'b1));
    tbl.push_back(ST(3'b001, 32'h13,   32'h00001234, 1'b1));
    tbl.push_back(LD(3'b010, 32'h10,   32'hDE5ABEEF, 1'b0));
    tbl.push_back(LD(3'b011, 32'h10,   32'h0,        1'b1));
    tbl.push_back(ST(3'b011, 32'h10,   32'h00000000, 1'b1));
    tbl.push_back(LD(3'b010, 32'h10,   32'hDE5ABEEF, 1'b0));
    tbl.push_back(ST(3'b001, 32'h12,   32'hFFFF1234, 1'b0));
    tbl.push_back(LD(3'b010, 32'h10,   32'h1234BEEF, 1'b0));
    tbl.push_back(ST(3'b010, 32'h24,   32'h33333333, 1'b0));
    tbl.push_back(ST(3'b010, 32'h1000, 32'hCAFEF00D, 1'b0));
    tbl.push_back(LD(3'b010, 32'h0,    32'hCAFEF00D, 1'b0));
    tbl.push_back(PASS());
    foreach (tbl[i]) step(tbl[i]);

    // stalled store: W holds the pass-through values, then the store lands once
    pre = last;
    v = ST(3'b010, 32'h20, 32'h11111111, 1'b0);
    for (int i = 0; i < 3; i++) step(STALLED(v, pre));
    step(v);
    step(LD(3'b010, 32'h20, 32'h11111111, 1'b0));

    // a store stalled and then squashed must never reach the RAM
    pre = last;
    v = ST(3'b010, 32'h20, 32'h44444444, 1'b0);
    for (int i = 0; i < 2; i++) step(STALLED(v, pre));
    v.fl = 1'b1;
    step(BUB(v));
    step(LD(3'b010, 32'h20, 32'h11111111, 1'b0));

    v = ST(3'b010, 32'h24, 32'h22222222, 1'b0);
    v.fl = 1'b1;
    step(BUB(v));
    step(LD(3'b010, 32'h24, 32'h33333333, 1'b0));

    v = ST(3'b010, 32'h24, 32'h55555555, 1'b0);
    v.fl = 1'b1; v.st = 1'b1;
    step(BUB(v));
    step(LD(3'b010, 32'h24, 32'h33333333, 1'b0));

    v = ST(3'b010, 32'h24, 32'h66666666, 1'b0);
    v.rst = 1'b0; v.st = 1'b1;
    step(BUB(v));
    step(LD(3'b010, 32'h24, 32'h33333333, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
